vector_lane_serializer: RTL and testbench

Streams the 32-bit lanes of a 128-bit vector register out one per handshake, starting at a selected lane and wrapping modulo the lane count. It is the read-side counterpart of the scalar-to-lane insert path. It sits between the vector register file read port and the scalar writeback/store path, so a vector can be drained to scalar consumers without a multi-port read.

---
 rtl/vector_pkg.sv | 31 +++
 rtl/vector_lane_select.sv | 21 ++
 rtl/vector_lane_serializer.sv | 134 +++++++++++++
 tb/tb_vector_lane_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared types and constants for the vector lane datapath (insert/extract and
// serializer paths).
//   LANES        : number of N-bit lanes in a V-bit vector register
//   lane_idx_t   : lane index (0..LANES-1)
//   lane_cnt_t   : lane count (1..LANES, 0 encodes a full vector)
//   ser_state_t  : serializer control states
//   norm_lane_count : maps an encoded count to the number of lanes to emit
// -----------------------------------------------------------------------------
package vector_pkg;

  localparam int LANES = 4;

  typedef logic [1:0] lane_idx_t;
  typedef logic [2:0] lane_cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A count of 0 means "the whole vector".
  function automatic lane_cnt_t norm_lane_count(input lane_cnt_t cnt);
    if (cnt == '0) begin
      return lane_cnt_t'(LANES);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vector_lane_select.sv
// -----------------------------------------------------------------------------
// vector_lane_select
// Combinational V-to-N lane multiplexer. Lane i occupies bits [N*i +: N].
// Ports:
//   vec_i  : V-bit source vector
//   idx_i  : lane index to extract
//   lane_o : selected N-bit lane
// -----------------------------------------------------------------------------
module vector_lane_select #(
  parameter int V  = 128,
  parameter int N  = 32,
  parameter int IW = (V / N > 1) ? $clog2(V / N) : 1
) (
  input  logic [V-1:0]  vec_i,
  input  logic [IW-1:0] idx_i,
  output logic [N-1:0]  lane_o
);

  assign lane_o = vec_i[N*idx_i +: N];

endmodule

// File: rtl/vector_lane_serializer.sv
// -----------------------------------------------------------------------------
// vector_lane_serializer
// Streams the N-bit lanes of a V-bit vector one per output handshake, starting
// at a selected lane and wrapping modulo the lane count.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready: input handshake for vector_input/start_lane/lane_count
//   vector_input     : source vector, captured at acceptance
//   start_lane       : first lane to emit
//   lane_count       : lanes to emit (1..4, 0 means 4)
//   out_valid/out_ready : output handshake
//   dst, out_lane, out_last : emitted lane data, its index, final-lane flag
//   dst_parity       : even parity over dst (only with VSER_PARITY_EN)
// Optional feature macro: VSER_PARITY_EN
// in_ready is combinational from out_ready; every other output is registered.
// -----------------------------------------------------------------------------
module vector_lane_serializer
  import vector_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [V-1:0] vector_input,
  input  lane_idx_t    start_lane,
  input  lane_cnt_t    lane_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dst,
  output lane_idx_t    out_lane,
  output logic         out_last
`ifdef VSER_PARITY_EN
  ,
  output logic         dst_parity
`endif
);

  ser_state_t   state_q, state_d;
  logic [V-1:0] vec_q, vec_d;
  lane_idx_t    cur_q, cur_d;
  lane_cnt_t    rem_q, rem_d;
  logic [N-1:0] dst_q, dst_d;

  logic         out_hs;
  logic         last_beat;
  logic         accept;
  logic [V-1:0] sel_vec;
  lane_idx_t    sel_idx;
  logic [N-1:0] sel_lane;

  assign last_beat = (rem_q == lane_cnt_t'(1));
  assign out_hs    = (state_q == SEND) && out_ready;
  assign in_ready  = (state_q == IDLE) || (out_hs && last_beat);
  assign accept    = in_valid && in_ready;

  // The next lane comes either from the vector being accepted this cycle or
  // from the captured vector one lane further on (2-bit add wraps 3 -> 0).
  assign sel_vec = accept ? vector_input : vec_q;
  assign sel_idx = accept ? start_lane : lane_idx_t'(cur_q + 2'd1);

  vector_lane_select #(
    .V (V),
    .N (N)
  ) u_lane_select (
    .vec_i  (sel_vec),
    .idx_i  (sel_idx),
    .lane_o (sel_lane)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    dst_d   = dst_q;
    if (accept) begin
      state_d = SEND;
      vec_d   = vector_input;
      cur_d   = start_lane;
      rem_d   = norm_lane_count(lane_count);
      dst_d   = sel_lane;
    end else if (out_hs) begin
      if (last_beat) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        cur_d = lane_idx_t'(cur_q + 2'd1);
        rem_d = rem_q - lane_cnt_t'(1);
        dst_d = sel_lane;
      end
    end
  end

  // ---- state / output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      dst_q   <= dst_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign dst       = dst_q;
  assign out_lane  = cur_q;
  assign out_last  = (state_q == SEND) && last_beat;

`ifdef VSER_PARITY_EN
  logic parity_q;

  // Parity follows dst_d so it is updated and held exactly like dst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^dst_d;
    end
  end

  assign dst_parity = parity_q;
`endif

endmodule

// File: tb/tb_vector_lane_serializer.sv
module tb_vector_lane_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] vector_input;
  logic [1:0]   start_lane;
  logic [2:0]   lane_count;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  dst;
  logic [1:0]   out_lane;
  logic         out_last;
`ifdef VSER_PARITY_EN
  logic         dst_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  lane;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  vector_lane_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .vector_input (vector_input),
    .start_lane   (start_lane),
    .lane_count   (lane_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .dst          (dst),
    .out_lane     (out_lane),
    .out_last     (out_last)
`ifdef VSER_PARITY_EN
    ,
    .dst_parity   (dst_parity)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an accepted vector becomes the list of lanes it will emit.
  task automatic model_push(input logic [127:0] v, input logic [1:0] sl, input logic [2:0] lc);
    int n;
    n = (lc == 0) ? 4 : int'(lc);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      int    l;
      l      = (int'(sl) + k) % 4;
      b.lane = 2'(l);
      b.data = 32'(v >> (32 * l));
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle: drive after negedge, check, then advance the model at posedge.
  task automatic step(input bit iv, input logic [127:0] v, input logic [1:0] sl,
                      input logic [2:0] lc, input bit ordy);
    bit exp_v, exp_ir, hs, acc;
    in_valid     = iv;
    vector_input = v;
    start_lane   = sl;
    lane_count   = lc;
    out_ready    = ordy;
    #1;
    exp_v  = (exp_q.size() != 0);
    exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    check("out_valid", out_valid, exp_v);
    check("in_ready", in_ready, exp_ir);
    if (exp_v) begin
      check("dst", dst, exp_q[0].data);
      check("out_lane", out_lane, exp_q[0].lane);
      check("out_last", out_last, exp_q[0].last);
`ifdef VSER_PARITY_EN
      check("dst_parity", dst_parity, ^exp_q[0].data);
`endif
    end
    hs  = exp_v && ordy;
    acc = iv && exp_ir;
    @(posedge clk);
    if (hs) void'(exp_q.pop_front());
    if (acc) model_push(v, sl, lc);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, '0, 2'd0, 3'd0, 1'b1);
    check("drained", exp_q.size(), 0);
  endtask

  logic [127:0] vec_a;
  logic [127:0] vec_b;

  initial begin
    vec_a        = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    vec_b        = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    vector_input = '0;
    start_lane   = '0;
    lane_count   = '0;
    out_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst dst", dst, 0);
    check("rst out_lane", out_lane, 0);
    check("rst out_last", out_last, 0);
    check("rst in_ready", in_ready, 1);
`ifdef VSER_PARITY_EN
    check("rst dst_parity", dst_parity, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Full vector from lane 0.
    step(1'b1, vec_a, 2'd0, 3'd4, 1'b1);
    drain();
    // Start at lane 3, three lanes: wraps to 0,1.
    step(1'b1, vec_a, 2'd3, 3'd3, 1'b1);
    drain();
    // Count 0 means four lanes, from lane 2.
    step(1'b1, vec_a, 2'd2, 3'd0, 1'b1);
    drain();

    // Backpressure on the second lane; in_valid held to show nothing is taken.
    step(1'b1, vec_b, 2'd0, 3'd4, 1'b1);
    step(1'b0, '0, 2'd0, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, vec_a, 2'd1, 3'd2, 1'b0);
    drain();

    // Back-to-back single-lane vectors with in_valid held.
    step(1'b1, vec_a, 2'd1, 3'd1, 1'b1);
    step(1'b1, vec_b, 2'd2, 3'd1, 1'b1);
    step(1'b1, vec_a, 2'd3, 3'd1, 1'b1);
    drain();

    // Odd-parity lane value.
    step(1'b1, 128'h0000_0000_0000_0000_0000_0000_0000_0007, 2'd0, 3'd1, 1'b1);
    drain();

    // Asynchronous reset mid-SEND, observed before the next rising edge.
    step(1'b1, vec_b, 2'd1, 3'd4, 1'b1);
    step(1'b0, '0, 2'd0, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst dst", dst, 0);
    check("async rst in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the lane-list model.
    for (int i = 0; i < 400; i++) begin
      logic [127:0] rv;
      rv = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 3) != 0), rv, 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
